// File: rtl/ext_pipe_if.sv
// Handshake bundle for ext_pipe: upstream beat (immediate, mode, tag) and downstream result.
// The slave side is the extension unit; the master side is whoever feeds and drains it.
interface ext_pipe_if #(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [IMM_W-1:0]  in_imm;
    logic [1:0]        in_op;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output in_valid, in_imm, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_imm, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/ext_pipe.sv
// Pipelined immediate extender: combinational zero/sign/high/branch-offset extension
// registered into a main slot backed by a one-entry skid slot, plus a wrapping beat counter.
module ext_pipe #(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    ext_pipe_if.slave        bus,
    output logic [CNT_W-1:0] beat_cnt
);
    localparam int EXT_W = DATA_W - IMM_W;

    logic [DATA_W-1:0] w_zext;
    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_high;
    logic [DATA_W-1:0] w_ext;
    logic              w_inReady;
    logic              w_accept;
    logic              w_emit;

    logic              r_mainValid;
    logic [DATA_W-1:0] r_mainData;
    logic [TAG_W-1:0]  r_mainTag;
    logic              r_skidValid;
    logic [DATA_W-1:0] r_skidData;
    logic [TAG_W-1:0]  r_skidTag;
    logic [CNT_W-1:0]  r_beatCnt;

    assign w_zext = {{EXT_W{1'b0}}, bus.in_imm};
    assign w_sext = {{EXT_W{bus.in_imm[IMM_W-1]}}, bus.in_imm};
    assign w_high = {bus.in_imm, {EXT_W{1'b0}}};

    // Branch offset: shifting the full sign extension left by 2 drops its top two bits.
    always_comb begin
        w_ext = w_zext;
        unique case (bus.in_op)
            2'b00: w_ext = w_zext;
            2'b01: w_ext = w_sext;
            2'b10: w_ext = w_high;
            2'b11: w_ext = w_sext << 2;
        endcase
    end

    assign w_inReady = !r_skidValid && !flush && !rst;
    assign w_accept  = bus.in_valid && w_inReady;
    assign w_emit    = r_mainValid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mainValid <= 1'b0;
            r_mainData  <= '0;
            r_mainTag   <= '0;
            r_skidValid <= 1'b0;
            r_skidData  <= '0;
            r_skidTag   <= '0;
            r_beatCnt   <= '0;
        end else if (flush) begin
            r_mainValid <= 1'b0;
            r_skidValid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_beatCnt <= r_beatCnt + 1'b1;
            end
            if (w_emit && r_skidValid) begin
                r_mainData  <= r_skidData;
                r_mainTag   <= r_skidTag;
                r_skidValid <= 1'b0;
            end else if (!r_mainValid || w_emit) begin
                r_mainValid <= w_accept;
                if (w_accept) begin
                    r_mainData <= w_ext;
                    r_mainTag  <= bus.in_tag;
                end
            end else if (w_accept) begin
                r_skidValid <= 1'b1;
                r_skidData  <= w_ext;
                r_skidTag   <= bus.in_tag;
            end
        end
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = r_mainValid;
    assign bus.out_data  = r_mainData;
    assign bus.out_tag   = r_mainTag;
    assign beat_cnt      = r_beatCnt;
endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: a two-deep FIFO reference model with arithmetic extension,
// directed scenarios, randomized traffic, and a second narrow-width instance for wrap checks.
module tb_ext_pipe;
    logic        clk = 1'b0;
    logic        rst0;
    logic        flush0;
    logic [15:0] cnt0;
    logic        rst1;
    logic        flush1;
    logic [3:0]  cnt1;

    int nCompared   = 0;
    int nMismatched = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
    } beat_t;

    beat_t       q[$];
    logic [15:0] mCnt;
    bit          modelValid = 0;
    bit          zeroKnown  = 0;

    ext_pipe_if #(.IMM_W(16), .DATA_W(32), .TAG_W(5)) bus0 ();
    ext_pipe_if #(.IMM_W(12), .DATA_W(24), .TAG_W(5)) bus1 ();

    ext_pipe #(.IMM_W(16), .DATA_W(32), .TAG_W(5), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst0), .flush(flush0), .bus(bus0.slave), .beat_cnt(cnt0)
    );

    ext_pipe #(.IMM_W(12), .DATA_W(24), .TAG_W(5), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst1), .flush(flush1), .bus(bus1.slave), .beat_cnt(cnt1)
    );

    always #5 clk = ~clk;

    // Reference extension from the mode definitions using plain integer arithmetic.
    function automatic logic [63:0] refExt(input logic [63:0] imm, input logic [1:0] op,
                                           input int immW, input int dataW);
        longint v, sv, mask, r;
        v    = longint'(imm);
        sv   = (v >= (longint'(1) << (immW - 1))) ? v - (longint'(1) << immW) : v;
        mask = (longint'(1) << dataW) - 1;
        case (op)
            2'd0:    r = v;
            2'd1:    r = sv;
            2'd2:    r = v * (longint'(1) << (dataW - immW));
            default: r = sv * 4;
        endcase
        return 64'(r & mask);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock of stimulus on dut0: drive, check against the model mid-cycle, advance the model.
    task automatic applyStimulus(input logic r, input logic f, input logic v, input logic [15:0] imm,
                                 input logic [1:0] op, input logic [4:0] tag, input logic rdy);
        logic        expReady;
        logic        acc;
        logic        emit;
        logic [63:0] e;
        beat_t       b;
        rst0 = r;
        flush0 = f;
        bus0.in_valid = v;
        bus0.in_imm = imm;
        bus0.in_op = op;
        bus0.in_tag = tag;
        bus0.out_ready = rdy;
        @(negedge clk);
        expReady = !r && !f && (q.size() < 2);
        checkOutput("in_ready", 64'(bus0.in_ready), 64'(expReady));
        if (modelValid) begin
            checkOutput("out_valid", 64'(bus0.out_valid), 64'(q.size() > 0));
            if (q.size() > 0) begin
                checkOutput("out_data", 64'(bus0.out_data), 64'(q[0].data));
                checkOutput("out_tag", 64'(bus0.out_tag), 64'(q[0].tag));
            end else if (zeroKnown) begin
                checkOutput("reset_data", 64'(bus0.out_data), 64'd0);
                checkOutput("reset_tag", 64'(bus0.out_tag), 64'd0);
            end
            checkOutput("beat_cnt", 64'(cnt0), 64'(mCnt));
        end
        acc  = v && expReady;
        emit = (q.size() > 0) && rdy;
        e = refExt(64'(imm), op, 16, 32);
        b.data = e[31:0];
        b.tag  = tag;
        @(posedge clk);
        if (r) begin
            q.delete();
            mCnt = '0;
            modelValid = 1;
            zeroKnown = 1;
        end else if (f) begin
            q.delete();
        end else begin
            if (emit) void'(q.pop_front());
            if (acc) begin
                q.push_back(b);
                mCnt++;
                zeroKnown = 0;
            end
        end
        #1;
    endtask

    task automatic idle(input logic rdy);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 2'b00, 5'd0, rdy);
    endtask

    logic [31:0] modeExp[5] = '{32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004, 32'h0000000C};
    logic [15:0] savedCnt;

    initial begin
        rst0 = 1'b1;
        flush0 = 1'b0;
        rst1 = 1'b1;
        flush1 = 1'b0;
        bus1.in_valid = 1'b0;
        bus1.in_imm = '0;
        bus1.in_op = 2'b00;
        bus1.in_tag = '0;
        bus1.out_ready = 1'b1;
        #1;

        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 2'b00, 5'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h1234, 2'b01, 5'd3, 1'b1);

        // Streaming: eight back-to-back beats
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b0, 1'b0, 1'b1, 16'($urandom), 2'($urandom_range(3)), 5'(i), 1'b1);
        idle(1'b1);
        checkOutput("stream_cnt", 64'(cnt0), 64'd8);

        // Mode values against literal results
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, (i == 4) ? 16'h0003 : 16'h8001,
                          (i == 4) ? 2'b11 : 2'(i), 5'(i + 10), 1'b1);
            checkOutput("mode_lit", 64'(bus0.out_data), 64'(modeExp[i]));
        end
        idle(1'b1);

        // Back-pressure: A, B accepted, C held, then drain
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hAAAA, 2'b00, 5'd1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hBBBB, 2'b01, 5'd2, 1'b0);
        checkOutput("bp_full", 64'(bus0.in_ready), 64'd0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, 1'b1, 16'hCCCC, 2'b10, 5'd3, 1'b0);
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 1'b0, 1'b1, 16'hCCCC, 2'b10, 5'd3, (q.size() > 0 || i > 0) ? 1'b1 : 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Flush with both slots full and a beat offered
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h1111, 2'b01, 5'd4, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h2222, 2'b01, 5'd5, 1'b0);
        savedCnt = mCnt;
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h3333, 2'b01, 5'd6, 1'b0);
        checkOutput("flush_valid", 64'(bus0.out_valid), 64'd0);
        checkOutput("flush_cnt", 64'(cnt0), 64'(savedCnt));
        idle(1'b1);
        idle(1'b1);

        // Reset mid-stream with two beats held
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h4444, 2'b11, 5'd7, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h5555, 2'b11, 5'd8, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h6666, 2'b11, 5'd9, 1'b1);
        checkOutput("rst_valid", 64'(bus0.out_valid), 64'd0);
        checkOutput("rst_cnt", 64'(cnt0), 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 2'b00, 5'd0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            applyStimulus(1'($urandom_range(60) == 0), 1'($urandom_range(25) == 0),
                          1'($urandom_range(3) != 0), 16'($urandom), 2'($urandom_range(3)),
                          5'($urandom), 1'($urandom_range(2) != 0));

        // Narrow instance: 12-bit immediate, 24-bit data, 4-bit counter
        rst0 = 1'b1;
        bus0.in_valid = 1'b0;
        rst1 = 1'b1;
        @(posedge clk);
        #1;
        rst1 = 1'b0;
        bus1.in_valid = 1'b1;
        bus1.in_imm = 12'h800;
        bus1.in_op = 2'b01;
        bus1.out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus1.in_tag = 5'(i);
            @(posedge clk);
            #1;
            checkOutput("narrow_data", 64'(bus1.out_data), 64'hFFF800);
            checkOutput("narrow_tag", 64'(bus1.out_tag), 64'(i));
        end
        bus1.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("narrow_wrap", 64'(cnt1), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
